// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the decode-stage branch hazard controller:
//   - opcodes of the control-transfer instructions the resolver handles
//   - FSM state type for the stall/resolve sequencer
//   - stall_need(): how many stall cycles a detected hazard costs
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

    localparam logic [6:0] BrOp = 7'b1100011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] JAL  = 7'b1101111;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } br_state_t;

    // An EX writer reaches the RF two cycles later and a MEM writer one cycle
    // later. Without a write-first RF the value shows up one cycle after WB.
    // The EX hazard wins because it is the later of the two writes.
    function automatic logic [1:0] stall_need(input logic haz_ex,
                                              input logic haz_mem,
                                              input logic wb_bypass);
        logic [1:0] need;
        need = 2'd0;
        if (haz_ex) begin
            need = wb_bypass ? 2'd2 : 2'd3;
        end else if (haz_mem) begin
            need = wb_bypass ? 2'd1 : 2'd2;
        end
        return need;
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// ---------------------------------------------------------------------------
// branch_hazard_detect
// Combinational decode of the IF/ID instruction: flags control-transfer
// instructions and RAW hazards against the in-flight EX and MEM writers.
// Ports:
//   i_id_instr  [31:0] instruction held in IF/ID
//   i_id_valid         IF/ID holds a valid instruction
//   i_ex_rd/i_ex_we    destination and write-enable of the EX instruction
//   i_mem_rd/i_mem_we  destination and write-enable of the MEM instruction
//   o_is_ctl           instruction is BRANCH, JAL or JALR
//   o_haz_ex           a used source matches the EX destination
//   o_haz_mem          a used source matches the MEM destination
// ---------------------------------------------------------------------------
module branch_hazard_detect
    import branch_ctrl_pkg::*;
(
    input  logic [31:0] i_id_instr,
    input  logic        i_id_valid,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_we,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_we,
    output logic        o_is_ctl,
    output logic        o_haz_ex,
    output logic        o_haz_mem
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_is_ctl;
    logic       w_unused_bits;

    assign w_opcode      = i_id_instr[6:0];
    assign w_rs1         = i_id_instr[19:15];
    assign w_rs2         = i_id_instr[24:20];
    assign w_unused_bits = ^{i_id_instr[31:25], i_id_instr[14:7]};

    // JAL computes its target from the PC alone, so it reads no register.
    always_comb begin
        w_is_ctl  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            BrOp: begin
                w_is_ctl  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            JALR: begin
                w_is_ctl  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            JAL: begin
                w_is_ctl  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A writer to x0 never changes the RF, so rd == 0 cannot create a hazard.
    assign o_haz_ex  = i_id_valid & w_is_ctl & i_ex_we & (i_ex_rd != 5'd0) &
                       ((w_use_rs1 & (w_rs1 == i_ex_rd)) |
                        (w_use_rs2 & (w_rs2 == i_ex_rd)));
    assign o_haz_mem = i_id_valid & w_is_ctl & i_mem_we & (i_mem_rd != 5'd0) &
                       ((w_use_rs1 & (w_rs1 == i_mem_rd)) |
                        (w_use_rs2 & (w_rs2 == i_mem_rd)));
    assign o_is_ctl  = w_is_ctl;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
// Sequences the decode-stage branch resolver: stalls IF/ID and bubbles ID/EX
// until branch operands are visible in the RF, then qualifies the resolver's
// taken output into a PC redirect and IF/ID flush. Keeps perf counters.
// Parameters:
//   CNT_W      width of each saturating perf counter
//   WB_BYPASS  1: RF is write-first; 0: WB result readable one cycle later
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_id_instr/valid    IF/ID instruction (held while o_stall_id = 1)
//   i_ex_rd/we          EX-stage writer
//   i_mem_rd/we         MEM-stage writer
//   i_br_take           raw resolver taken/jump output
//   i_ext_flush         trap flush, aborts any stall
//   i_perf_clr          synchronous clear of the perf counters
//   o_stall_id          hold PC and IF/ID
//   o_bubble_ex         load NOP into ID/EX
//   o_pc_redirect       PC takes the branch target
//   o_flush_ifid        kill the fetched instruction
//   o_br_cnt            control instructions resolved
//   o_taken_cnt         redirects issued
//   o_stall_cnt         stall cycles
// ---------------------------------------------------------------------------
module branch_hazard_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter bit WB_BYPASS = 1'b1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_id_instr,
    input  logic             i_id_valid,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_we,
    input  logic [4:0]       i_mem_rd,
    input  logic             i_mem_we,
    input  logic             i_br_take,
    input  logic             i_ext_flush,
    input  logic             i_perf_clr,
    output logic             o_stall_id,
    output logic             o_bubble_ex,
    output logic             o_pc_redirect,
    output logic             o_flush_ifid,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    br_state_t        r_state;
    logic [1:0]       r_remain;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    br_state_t        w_next_state;
    logic [1:0]       w_next_remain;
    logic [1:0]       w_need;
    logic             w_is_ctl;
    logic             w_haz_ex;
    logic             w_haz_mem;
    logic             w_stall;
    logic             w_redirect;
    logic             w_resolved;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        return (en && (value != {CNT_W{1'b1}})) ? value + CNT_W'(1) : value;
    endfunction

    branch_hazard_detect u_detect (
        .i_id_instr (i_id_instr),
        .i_id_valid (i_id_valid),
        .i_ex_rd    (i_ex_rd),
        .i_ex_we    (i_ex_we),
        .i_mem_rd   (i_mem_rd),
        .i_mem_we   (i_mem_we),
        .o_is_ctl   (w_is_ctl),
        .o_haz_ex   (w_haz_ex),
        .o_haz_mem  (w_haz_mem)
    );

    assign w_need = stall_need(w_haz_ex, w_haz_mem, WB_BYPASS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_remain <= 2'd0;
        end else begin
            r_state  <= w_next_state;
            r_remain <= w_next_remain;
        end
    end

    // The detection cycle already stalls, so the counter is loaded with N-1
    // and STALL is skipped entirely when one stall cycle is enough. RESOLVE
    // trusts the stall count and does not re-check hazards. A killed
    // instruction under ext_flush is not counted as resolved.
    always_comb begin
        w_next_state  = r_state;
        w_next_remain = r_remain;
        w_stall       = 1'b0;
        w_redirect    = 1'b0;
        w_resolved    = 1'b0;
        case (r_state)
            RUN: begin
                if (w_need != 2'd0) begin
                    w_stall       = 1'b1;
                    w_next_remain = w_need - 2'd1;
                    w_next_state  = (w_need > 2'd1) ? STALL : RESOLVE;
                end else begin
                    w_redirect = i_id_valid & w_is_ctl & i_br_take;
                    w_resolved = i_id_valid & w_is_ctl;
                end
            end
            STALL: begin
                w_stall       = 1'b1;
                w_next_remain = r_remain - 2'd1;
                if (r_remain <= 2'd1) begin
                    w_next_state = RESOLVE;
                end
            end
            RESOLVE: begin
                w_redirect   = i_br_take;
                w_resolved   = 1'b1;
                w_next_state = RUN;
            end
            default: begin
                w_next_state  = RUN;
                w_next_remain = 2'd0;
            end
        endcase
        if (i_ext_flush) begin
            w_stall       = 1'b0;
            w_redirect    = 1'b0;
            w_resolved    = 1'b0;
            w_next_state  = RUN;
            w_next_remain = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (i_perf_clr) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_br_cnt    <= sat_inc(r_br_cnt, w_resolved);
            r_taken_cnt <= sat_inc(r_taken_cnt, w_redirect);
            r_stall_cnt <= sat_inc(r_stall_cnt, w_stall);
        end
    end

    // Combinational outputs are gated by reset so nothing leaks out while
    // the core is held in reset with live inputs.
    assign o_stall_id    = rst_n & w_stall;
    assign o_bubble_ex   = rst_n & w_stall;
    assign o_pc_redirect = rst_n & w_redirect;
    assign o_flush_ifid  = rst_n & w_redirect;
    assign o_br_cnt      = r_br_cnt;
    assign o_taken_cnt   = r_taken_cnt;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_ctrl
// Drives two controllers (WB_BYPASS = 0 and 1) from the same stimulus and
// compares both against a cycle-count reference model of the branch rules.
// ---------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    localparam int CW   = 4;
    localparam int MAXC = 15;

    localparam logic [31:0] BEQ_5_6   = {7'b0, 5'd6, 5'd5, 3'b000, 5'd0, 7'b1100011};
    localparam logic [31:0] BLT_5_6   = {7'b0, 5'd6, 5'd5, 3'b100, 5'd0, 7'b1100011};
    localparam logic [31:0] BNE_0_0   = {7'b0, 5'd0, 5'd0, 3'b001, 5'd0, 7'b1100011};
    localparam logic [31:0] JALR_0_7  = {12'd0, 5'd7, 3'b000, 5'd0, 7'b1100111};
    localparam logic [31:0] JAL_1     = {20'd0, 5'd1, 7'b1101111};
    localparam logic [31:0] ADD_5_6   = {7'b0, 5'd6, 5'd5, 3'b000, 5'd1, 7'b0110011};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] idInstr;
    logic        idValid;
    logic [4:0]  exRd;
    logic        exWe;
    logic [4:0]  memRd;
    logic        memWe;
    logic        brTake;
    logic        extFlush;
    logic        perfClr;

    logic [1:0]          stallV;
    logic [1:0]          bubbleV;
    logic [1:0]          redirV;
    logic [1:0]          flushV;
    logic [1:0][CW-1:0]  brCntV;
    logic [1:0][CW-1:0]  takenCntV;
    logic [1:0][CW-1:0]  stallCntV;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model, index = WB_BYPASS value.
    // cyclesToResolve: 0 = free to take a new instruction, k = the resolve
    // cycle is k cycles away (stall until then).
    int cyclesToResolve [2];
    int mBr   [2];
    int mTaken[2];
    int mStall[2];
    bit prevStall;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.CNT_W(CW), .WB_BYPASS(1'b0)) dutNoByp (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_instr    (idInstr),
        .i_id_valid    (idValid),
        .i_ex_rd       (exRd),
        .i_ex_we       (exWe),
        .i_mem_rd      (memRd),
        .i_mem_we      (memWe),
        .i_br_take     (brTake),
        .i_ext_flush   (extFlush),
        .i_perf_clr    (perfClr),
        .o_stall_id    (stallV[0]),
        .o_bubble_ex   (bubbleV[0]),
        .o_pc_redirect (redirV[0]),
        .o_flush_ifid  (flushV[0]),
        .o_br_cnt      (brCntV[0]),
        .o_taken_cnt   (takenCntV[0]),
        .o_stall_cnt   (stallCntV[0])
    );

    branch_hazard_ctrl #(.CNT_W(CW), .WB_BYPASS(1'b1)) dutByp (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_instr    (idInstr),
        .i_id_valid    (idValid),
        .i_ex_rd       (exRd),
        .i_ex_we       (exWe),
        .i_mem_rd      (memRd),
        .i_mem_we      (memWe),
        .i_br_take     (brTake),
        .i_ext_flush   (extFlush),
        .i_perf_clr    (perfClr),
        .o_stall_id    (stallV[1]),
        .o_bubble_ex   (bubbleV[1]),
        .o_pc_redirect (redirV[1]),
        .o_flush_ifid  (flushV[1]),
        .o_br_cnt      (brCntV[1]),
        .o_taken_cnt   (takenCntV[1]),
        .o_stall_cnt   (stallCntV[1])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int satAdd(input int value, input bit en);
        return (en && value < MAXC) ? value + 1 : value;
    endfunction

    // Pulls reset low between clock edges, checks that everything reads zero
    // straight away, then releases it just after the next rising edge.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            checkOutput($sformatf("rst stall_id byp=%0d", b), 32'(stallV[b]), 32'd0);
            checkOutput($sformatf("rst bubble_ex byp=%0d", b), 32'(bubbleV[b]), 32'd0);
            checkOutput($sformatf("rst pc_redirect byp=%0d", b), 32'(redirV[b]), 32'd0);
            checkOutput($sformatf("rst flush_ifid byp=%0d", b), 32'(flushV[b]), 32'd0);
            checkOutput($sformatf("rst br_cnt byp=%0d", b), 32'(brCntV[b]), 32'd0);
            checkOutput($sformatf("rst taken_cnt byp=%0d", b), 32'(takenCntV[b]), 32'd0);
            checkOutput($sformatf("rst stall_cnt byp=%0d", b), 32'(stallCntV[b]), 32'd0);
            cyclesToResolve[b] = 0;
            mBr[b]    = 0;
            mTaken[b] = 0;
            mStall[b] = 0;
        end
        prevStall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare both DUTs with the model
    // mid-cycle, advance the model, step past the next rising edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                                 input logic [4:0] eRd, input logic eWe,
                                 input logic [4:0] mRd, input logic mWe,
                                 input logic take, input logic flush,
                                 input logic clr);
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit isCtl, useRs1, useRs2, hitEx, hitMem;
        bit eStall, eRedir, eResolved, anyStall;
        int need;

        idInstr  = instr;
        idValid  = valid;
        exRd     = eRd;
        exWe     = eWe;
        memRd    = mRd;
        memWe    = mWe;
        brTake   = take;
        extFlush = flush;
        perfClr  = clr;
        #2;

        op     = instr[6:0];
        rs1    = instr[19:15];
        rs2    = instr[24:20];
        useRs1 = (op == 7'b1100011) || (op == 7'b1100111);
        useRs2 = (op == 7'b1100011);
        isCtl  = useRs1 || (op == 7'b1101111);
        hitEx  = valid && isCtl && eWe && (eRd != 0) &&
                 ((useRs1 && rs1 == eRd) || (useRs2 && rs2 == eRd));
        hitMem = valid && isCtl && mWe && (mRd != 0) &&
                 ((useRs1 && rs1 == mRd) || (useRs2 && rs2 == mRd));
        anyStall = 1'b0;

        for (int b = 0; b < 2; b++) begin
            // Cycles until the operand is readable: EX writer is two stages
            // from the RF, MEM writer one; one more without write-first.
            need = hitEx ? (3 - b) : (hitMem ? (2 - b) : 0);
            if (cyclesToResolve[b] == 0) begin
                eStall    = (need > 0);
                eRedir    = !eStall && valid && isCtl && take;
                eResolved = !eStall && valid && isCtl;
            end else if (cyclesToResolve[b] > 1) begin
                eStall    = 1'b1;
                eRedir    = 1'b0;
                eResolved = 1'b0;
            end else begin
                eStall    = 1'b0;
                eRedir    = take;
                eResolved = 1'b1;
            end
            if (flush) begin
                eStall    = 1'b0;
                eRedir    = 1'b0;
                eResolved = 1'b0;
            end

            checkOutput($sformatf("stall_id byp=%0d", b), 32'(stallV[b]), 32'(eStall));
            checkOutput($sformatf("bubble_ex byp=%0d", b), 32'(bubbleV[b]), 32'(eStall));
            checkOutput($sformatf("pc_redirect byp=%0d", b), 32'(redirV[b]), 32'(eRedir));
            checkOutput($sformatf("flush_ifid byp=%0d", b), 32'(flushV[b]), 32'(eRedir));
            checkOutput($sformatf("br_cnt byp=%0d", b), 32'(brCntV[b]), 32'(mBr[b]));
            checkOutput($sformatf("taken_cnt byp=%0d", b), 32'(takenCntV[b]), 32'(mTaken[b]));
            checkOutput($sformatf("stall_cnt byp=%0d", b), 32'(stallCntV[b]), 32'(mStall[b]));

            anyStall = anyStall | eStall;
            if (flush)
                cyclesToResolve[b] = 0;
            else if (cyclesToResolve[b] == 0)
                cyclesToResolve[b] = need;
            else
                cyclesToResolve[b] = cyclesToResolve[b] - 1;

            if (clr) begin
                mBr[b]    = 0;
                mTaken[b] = 0;
                mStall[b] = 0;
            end else begin
                mBr[b]    = satAdd(mBr[b], eResolved);
                mTaken[b] = satAdd(mTaken[b], eRedir);
                mStall[b] = satAdd(mStall[b], eStall);
            end
        end
        prevStall = anyStall;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randomInstr();
        logic [31:0] instr;
        instr = $urandom;
        case ($urandom_range(0, 3))
            0: instr[6:0] = 7'b1100011;
            1: instr[6:0] = 7'b1100111;
            2: instr[6:0] = 7'b1101111;
            default: instr[6:0] = 7'b0110011;
        endcase
        instr[19:15] = 5'($urandom_range(0, 3));
        instr[24:20] = 5'($urandom_range(0, 3));
        return instr;
    endfunction

    initial begin
        logic [31:0] curInstr;
        logic        curValid;

        rst_n    = 1'b1;
        idInstr  = BEQ_5_6;
        idValid  = 1'b1;
        exRd     = 5'd5;
        exWe     = 1'b1;
        memRd    = 5'd6;
        memWe    = 1'b1;
        brTake   = 1'b1;
        extFlush = 1'b0;
        perfClr  = 1'b0;
        #1;
        doReset();

        // BEQ x5,x6 with EX writing x5: 2 stalls (bypass) / 3 stalls (no bypass)
        applyStimulus(BEQ_5_6, 1, 5'd5, 1, 5'd0, 0, 0, 0, 0);
        applyStimulus(BEQ_5_6, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        applyStimulus(BEQ_5_6, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        applyStimulus(ADD_5_6, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        checkOutput("beq stall_cnt byp=1", 32'(stallCntV[1]), 32'd2);
        checkOutput("beq stall_cnt byp=0", 32'(stallCntV[0]), 32'd3);
        checkOutput("beq taken_cnt byp=1", 32'(takenCntV[1]), 32'd1);
        checkOutput("beq taken_cnt byp=0", 32'(takenCntV[0]), 32'd1);

        // JALR x0,0(x7) with MEM writing x7
        doReset();
        applyStimulus(JALR_0_7, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0);
        applyStimulus(JALR_0_7, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        applyStimulus(ADD_5_6, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        checkOutput("jalr stall_cnt byp=1", 32'(stallCntV[1]), 32'd1);
        checkOutput("jalr taken_cnt byp=1", 32'(takenCntV[1]), 32'd1);
        checkOutput("jalr br_cnt byp=1", 32'(brCntV[1]), 32'd1);
        checkOutput("jalr stall_cnt byp=0", 32'(stallCntV[0]), 32'd2);

        // JAL ignores EX x1; BNE x0,x0 never hazards on x0
        applyStimulus(JAL_1, 1, 5'd1, 1, 5'd0, 0, 1, 0, 0);
        applyStimulus(BNE_0_0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0);

        // BLT with hazard on both EX and MEM, run to completion
        applyStimulus(BLT_5_6, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(BLT_5_6, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);

        // ext_flush in the second STALL cycle, then nothing redirects
        applyStimulus(BLT_5_6, 1, 5'd5, 1, 5'd6, 1, 1, 0, 0);
        applyStimulus(BLT_5_6, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        applyStimulus(BLT_5_6, 1, 5'd0, 0, 5'd0, 0, 1, 1, 0);
        applyStimulus(ADD_5_6, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        applyStimulus(ADD_5_6, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);

        // Reset while stalled
        applyStimulus(BLT_5_6, 1, 5'd5, 1, 5'd6, 1, 1, 0, 0);
        applyStimulus(BLT_5_6, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        doReset();

        // Saturation, then perf_clr beating a same-cycle increment
        for (int i = 0; i < 20; i++)
            applyStimulus(JAL_1, 1, 5'd0, 0, 5'd0, 0, 1, 0, 0);
        checkOutput("sat taken_cnt byp=1", 32'(takenCntV[1]), 32'(MAXC));
        checkOutput("sat br_cnt byp=0", 32'(brCntV[0]), 32'(MAXC));
        applyStimulus(JAL_1, 1, 5'd0, 0, 5'd0, 0, 1, 0, 1);
        checkOutput("clr taken_cnt byp=1", 32'(takenCntV[1]), 32'd0);
        checkOutput("clr br_cnt byp=0", 32'(brCntV[0]), 32'd0);

        // Randomized run; IF/ID is held while either controller stalls
        curInstr = randomInstr();
        curValid = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end
            if (!prevStall) begin
                curInstr = randomInstr();
                curValid = ($urandom_range(0, 7) != 0);
            end
            applyStimulus(curInstr, curValid,
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
